iq_modulate: RTL and testbench

//  Transmit-side counterpart of the IQ demodulator. Accepts baseband I/Q samples at
//  the low rate via valid/ready, linearly interpolates them by 2^INTERP_LOG2 to the
//  clk_in rate and mixes them onto the LO from an internal NCO.

---
 rtl/iq_modulate.sv | 234 +++++++++++++++++++++++
 tb/tb_iq_modulate.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_modulate.sv
// iq_modulate
//   Transmit-side IQ modulator. Baseband I/Q samples arrive at the low rate over a
//   valid/ready handshake. They are linearly interpolated by 2^INTERP_LOG2 up to the
//   clk_in rate and mixed onto a local oscillator from an internal NCO.
//   The result is the real IF signal I*cos - Q*sin.
//
// Ports
//   clk_in     system clock, all logic on the rising edge
//   RST        synchronous reset, active-high
//   LO_fre     NCO frequency word, f = LO_fre * f_clk / 2^32
//   I_IN       signed baseband I sample
//   Q_IN       signed baseband Q sample
//   iq_valid   I_IN/Q_IN hold a sample
//   iq_ready   module takes a sample this cycle (one cycle in 2^INTERP_LOG2)
//   IF_OUT     signed modulated IF sample, one per clk_in
//   underflow  sticky flag: a sample slot passed without iq_valid
//
// Pipeline
//   stage 1  interpolated y (from prev/cur/k), NCO phase accumulator
//   stage 2  quarter-wave table lookup -> cos/sin, y delayed to match
//   stage 3  products y_i*cos and y_q*sin
//   stage 4  difference, scaling, saturation -> IF_OUT
module iq_modulate #(
    parameter int INPUT_WIDTH  = 12,
    parameter int LO_WIDTH     = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int INTERP_LOG2  = 4,
    parameter int LUT_ADDR     = 8
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic [31:0]                    LO_fre,
    input  logic signed [INPUT_WIDTH-1:0]  I_IN,
    input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
    input  logic                           iq_valid,
    output logic                           iq_ready,
    output logic signed [OUTPUT_WIDTH-1:0] IF_OUT,
    output logic                           underflow
);

    localparam int IW    = INPUT_WIDTH;
    localparam int LW    = LO_WIDTH;
    localparam int OW    = OUTPUT_WIDTH;
    localparam int KW    = INTERP_LOG2;
    localparam int PW    = IW + LW;          // product width
    localparam int SW    = PW + 1;           // difference width
    localparam int SHIFT = PW - OW - 1;      // scaling of the difference onto IF_OUT
    localparam int XW    = IW + KW + 2;      // interpolation working width
    localparam int NLUT  = 2 ** LUT_ADDR;
    localparam int FRAC  = 30;               // fixed-point fraction bits for table build

    localparam logic [KW-1:0]        K_LAST      = {KW{1'b1}};
    localparam logic signed [SW-1:0] OUT_MAX     = SW'((2 ** (OW - 1)) - 1);
    localparam logic signed [SW-1:0] OUT_MIN     = SW'(-(2 ** (OW - 1)));
    localparam longint               HALF_PI_FIX = 64'sd1686629713;  // pi/2 * 2^30

    // Quarter-wave entry n = round(A * sin(pi/2 * (n + 0.5) / NLUT)).
    // The table is built at elaboration from a Taylor series in 2^-30 fixed point.
    // That error is far below half an LSB, so the rounded entries are exact.
    function automatic logic [LW-1:0] sin_entry(input int n);
        longint x;
        longint term;
        longint acc;
        longint amp;
        x    = (HALF_PI_FIX * longint'(2 * n + 1)) >>> (LUT_ADDR + 1);
        term = x;
        acc  = x;
        for (int i = 1; i <= 10; i++) begin
            term = -((((term * x) >>> FRAC) * x) >>> FRAC) / longint'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        amp = longint'((2 ** (LW - 1)) - 1);
        return LW'((acc * amp + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

    // y = p + floor((c - p) * k / 2^KW). The result always lies between p and c.
    function automatic logic signed [IW-1:0] interp(
        input logic signed [IW-1:0] p,
        input logic signed [IW-1:0] c,
        input logic [KW-1:0]        k
    );
        logic signed [XW-1:0] p_x;
        logic signed [XW-1:0] c_x;
        logic signed [XW-1:0] k_x;
        logic signed [XW-1:0] prod;
        logic signed [XW-1:0] y_x;
        p_x  = XW'(p);
        c_x  = XW'(c);
        k_x  = XW'(k);
        prod = (c_x - p_x) * k_x;
        y_x  = p_x + (prod >>> KW);
        return y_x[IW-1:0];
    endfunction

    // Full-precision signed multiply of a sample by an LO value.
    function automatic logic signed [PW-1:0] smul(
        input logic signed [IW-1:0] a,
        input logic signed [LW-1:0] b
    );
        logic signed [PW-1:0] a_x;
        logic signed [PW-1:0] b_x;
        a_x = PW'(a);
        b_x = PW'(b);
        return a_x * b_x;
    endfunction

    logic [LW-1:0] lut [NLUT];

    for (genvar n = 0; n < NLUT; n++) begin : g_lut
        localparam logic [LW-1:0] ENTRY = sin_entry(n);
        assign lut[n] = ENTRY;
    end

    logic [KW-1:0]          k_q,     k_d;
    logic                   ready_q, ready_d;
    logic                   uf_q,    uf_d;
    logic [2*IW-1:0]        prev_q,  prev_d;     // {I, Q}
    logic [2*IW-1:0]        cur_q,   cur_d;      // {I, Q}
    logic [31:0]            phase_q, phase_d;
    logic signed [IW-1:0]   yi_q,    yi_d;
    logic signed [IW-1:0]   yq_q,    yq_d;
    logic signed [IW-1:0]   yi2_q,   yi2_d;
    logic signed [IW-1:0]   yq2_q,   yq2_d;
    logic signed [LW-1:0]   cos_q,   cos_d;
    logic signed [LW-1:0]   sin_q,   sin_d;
    logic signed [PW-1:0]   pi_q,    pi_d;
    logic signed [PW-1:0]   pq_q,    pq_d;
    logic signed [OW-1:0]   if_q,    if_d;

    logic [LUT_ADDR-1:0]    idx;
    logic signed [LW-1:0]   tab_a;   // table at idx
    logic signed [LW-1:0]   tab_b;   // table at mirrored idx
    logic signed [SW-1:0]   diff;
    logic signed [SW-1:0]   scaled;

    // Next-state logic: slot counter, handshake, NCO and the four datapath stages.
    always_comb begin
        k_d     = k_q + KW'(1);
        ready_d = (k_d == K_LAST);
        uf_d    = uf_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        phase_d = phase_q + LO_fre;

        // The sample slot closes on every ready cycle whether or not a sample is present.
        if (ready_q) begin
            prev_d = cur_q;
            if (iq_valid) begin
                cur_d = {I_IN, Q_IN};
            end else begin
                cur_d = '0;
                uf_d  = 1'b1;
            end
        end else begin
            prev_d = prev_q;
        end

        // Stage 1: interpolation between the previous and current sample.
        yi_d = interp(prev_q[2*IW-1:IW], cur_q[2*IW-1:IW], k_q);
        yq_d = interp(prev_q[IW-1:0], cur_q[IW-1:0], k_q);

        // Stage 2: quarter-wave table lookup.
        // The mirrored index gives the complement, and the quadrant picks the signs.
        yi2_d = yi_q;
        yq2_d = yq_q;
        idx   = phase_q[29 -: LUT_ADDR];
        tab_a = lut[idx];
        tab_b = lut[~idx];
        case (phase_q[31:30])
            2'd0: begin cos_d =  tab_b; sin_d =  tab_a; end
            2'd1: begin cos_d = -tab_a; sin_d =  tab_b; end
            2'd2: begin cos_d = -tab_b; sin_d = -tab_a; end
            2'd3: begin cos_d =  tab_a; sin_d = -tab_b; end
            default: begin cos_d = tab_b; sin_d = tab_a; end
        endcase

        // Stage 3: mixing products.
        pi_d = smul(yi2_q, cos_q);
        pq_d = smul(yq2_q, sin_q);

        // Stage 4: I*cos - Q*sin, floor-scaled, clamped instead of wrapping.
        diff   = SW'(pi_q) - SW'(pq_q);
        scaled = diff >>> SHIFT;
        if (scaled > OUT_MAX) begin
            if_d = OUT_MAX[OW-1:0];
        end else if (scaled < OUT_MIN) begin
            if_d = OUT_MIN[OW-1:0];
        end else begin
            if_d = scaled[OW-1:0];
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            k_q     <= '0;
            ready_q <= 1'b0;
            uf_q    <= 1'b0;
            prev_q  <= '0;
            cur_q   <= '0;
            phase_q <= '0;
            yi_q    <= '0;
            yq_q    <= '0;
            yi2_q   <= '0;
            yq2_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            pi_q    <= '0;
            pq_q    <= '0;
            if_q    <= '0;
        end else begin
            k_q     <= k_d;
            ready_q <= ready_d;
            uf_q    <= uf_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            phase_q <= phase_d;
            yi_q    <= yi_d;
            yq_q    <= yq_d;
            yi2_q   <= yi2_d;
            yq2_q   <= yq2_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            pi_q    <= pi_d;
            pq_q    <= pq_d;
            if_q    <= if_d;
        end
    end

    assign iq_ready  = ready_q;
    assign underflow = uf_q;
    assign IF_OUT    = if_q;

endmodule

// File: tb/tb_iq_modulate.sv
// tb_iq_modulate
//   Directed bench for iq_modulate with default parameters (12/12/12, L=4, 256-entry table).
//   The LO values used below come from the quarter-wave table formula:
//     phase 0 : cos = 2047, sin = 6
//     45 deg  : cos = 1443, sin = 1452
module tb_iq_modulate;

    logic               clk_in;
    logic               RST;
    logic [31:0]        LO_fre;
    logic signed [11:0] I_IN;
    logic signed [11:0] Q_IN;
    logic               iq_valid;
    logic               iq_ready;
    logic signed [11:0] IF_OUT;
    logic               underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    iq_modulate dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .LO_fre    (LO_fre),
        .I_IN      (I_IN),
        .Q_IN      (Q_IN),
        .iq_valid  (iq_valid),
        .iq_ready  (iq_ready),
        .IF_OUT    (IF_OUT),
        .underflow (underflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps until iq_ready is seen (bounded) and returns the number of edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!iq_ready && n < 40);
    endtask

    task automatic settle();
        repeat (40) step();
    endtask

    initial begin
        int n;
        int bad;
        int pulses;
        int doubles;
        int mx;
        int mn;
        logic prev_rdy;
        int a [32];
        int b [16];

        RST      = 1'b1;
        LO_fre   = 32'd0;
        I_IN     = 12'sd0;
        Q_IN     = 12'sd0;
        iq_valid = 1'b1;

        // Reset state and first ready after release.
        repeat (5) step();
        check("rst_if_out", IF_OUT, 0);
        check("rst_ready", iq_ready, 0);
        check("rst_underflow", underflow, 0);
        RST = 1'b0;
        wait_ready(n);
        check("first_ready_edges", n, 15);

        // Step response 0 -> 1600: k=0 value shows 4 cycles after the slot start edge.
        I_IN = 12'sd1600;
        repeat (5) step();
        check("step_k0", IF_OUT, 0);
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("step_k%0d", k), IF_OUT, 100 * k - 1);
        end
        step();
        check("step_settle", IF_OUT, 1599);

        // DC levels at phase 0.
        I_IN = 12'sd1000;
        settle();
        check("dc_i_pos", IF_OUT, 999);
        I_IN = -12'sd1000;
        settle();
        check("dc_i_neg", IF_OUT, -1000);
        I_IN = 12'sd0;
        Q_IN = 12'sd1000;
        settle();
        check("dc_q_only", IF_OUT, -3);

        // A sample presented outside the ready cycle must be ignored.
        I_IN = 12'sd1000;
        Q_IN = 12'sd0;
        settle();
        wait_ready(n);
        step();
        I_IN = -12'sd1500;
        step();
        I_IN = 12'sd1000;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (IF_OUT !== 12'sd999) bad++;
        end
        check("stray_valid_ignored", bad, 0);

        // Preload 45 degrees, then hold the phase.
        LO_fre = 32'h2000_0000;
        step();
        LO_fre = 32'd0;
        settle();
        check("p45_i_only", IF_OUT, 704);
        I_IN = 12'sd0;
        Q_IN = 12'sd1000;
        settle();
        check("p45_q_only", IF_OUT, -709);
        I_IN = -12'sd2048;
        Q_IN = 12'sd2047;
        settle();
        check("sat_neg", IF_OUT, -2048);
        I_IN = 12'sd2047;
        Q_IN = -12'sd2048;
        settle();
        check("sat_pos", IF_OUT, 2047);

        // Phase wrap back to exactly 0.
        LO_fre = 32'hE000_0000;
        step();
        LO_fre = 32'd0;
        I_IN   = 12'sd1000;
        Q_IN   = 12'sd0;
        settle();
        check("wrap_phase0", IF_OUT, 999);

        // Tone at f_clk/16.
        LO_fre = 32'h1000_0000;
        I_IN   = 12'sd2047;
        repeat (48) step();
        for (int i = 0; i < 32; i++) begin
            step();
            a[i] = IF_OUT;
        end
        mx  = -5000;
        mn  = 5000;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a[i] > mx) mx = a[i];
            if (a[i] < mn) mn = a[i];
            if (a[i] != a[i + 16]) bad++;
        end
        check("tone_i_period16", bad, 0);
        check("tone_i_peak", mx, 2046);
        check("tone_i_trough", mn, -2047);
        I_IN = 12'sd0;
        Q_IN = 12'sd2047;
        repeat (48) step();
        for (int i = 0; i < 16; i++) begin
            step();
            b[i] = IF_OUT;
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tone_q_shift%0d", i), b[i], a[(i + 4) % 16]);
        end

        // Ready pulses: every 16 cycles, one cycle wide.
        LO_fre = 32'd0;
        Q_IN   = 12'sd0;
        pulses   = 0;
        doubles  = 0;
        prev_rdy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (iq_ready) pulses++;
            if (iq_ready && prev_rdy) doubles++;
            prev_rdy = iq_ready;
        end
        check("ready_pulse_count", pulses, 4);
        check("ready_pulse_width", doubles, 0);

        // Missed slot sets the sticky underflow and injects zeros.
        I_IN = 12'sd1000;
        wait_ready(n);
        check("uf_sync_ready", iq_ready, 1);
        check("uf_before", underflow, 0);
        iq_valid = 1'b0;
        step();
        check("uf_set", underflow, 1);
        settle();
        check("uf_zero_fill", IF_OUT, 0);
        iq_valid = 1'b1;
        settle();
        check("uf_sticky", underflow, 1);

        // Reset mid-stream clears everything and discards held samples.
        RST = 1'b1;
        repeat (5) step();
        check("mid_rst_if_out", IF_OUT, 0);
        check("mid_rst_ready", iq_ready, 0);
        check("mid_rst_underflow", underflow, 0);
        I_IN = 12'sd0;
        RST  = 1'b0;
        wait_ready(n);
        check("mid_rst_first_ready", n, 15);
        check("mid_rst_discard", IF_OUT, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
